gfx_pattern_gen: RTL and testbench



---
 rtl/gfx_pattern_gen.sv | 162 ++++++++++++++++
 tb/tb_gfx_pattern_gen.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/gfx_pattern_gen.sv
// Raster test-pattern source: walks one visible frame and emits (x, y, {r,g,b}) beats.
// Latency: first beat valid one cycle after the accepted start; one beat per cycle while ready.
// Backpressure: valid/ready; beat contents hold while stalled; all outputs registered.
module gfx_pattern_gen #(
    parameter int H_VISIBLE   = 640,
    parameter int V_VISIBLE   = 480,
    parameter int H_WIDTH     = 12,
    parameter int V_WIDTH     = 12,
    parameter int COLOR_WIDTH = 4,
    localparam int PIXEL_WIDTH = 3 * COLOR_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [1:0]             pattern,
    input  logic [PIXEL_WIDTH-1:0] fill_color,
    output logic                   busy,
    output logic                   done,
    output logic                   m_gfx_valid,
    input  logic                   m_gfx_ready,
    output logic [H_WIDTH-1:0]     m_gfx_x,
    output logic [V_WIDTH-1:0]     m_gfx_y,
    output logic [PIXEL_WIDTH-1:0] m_gfx_pixel
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int BAR_W = H_VISIBLE / 8;
    localparam int BC_W  = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [H_WIDTH-1:0] X_LAST  = H_WIDTH'(H_VISIBLE - 1);
    localparam logic [V_WIDTH-1:0] Y_LAST  = V_WIDTH'(V_VISIBLE - 1);
    localparam logic [BC_W-1:0]    BC_LAST = BC_W'(BAR_W - 1);

    logic [1:0]             state_q,   state_d;
    logic [H_WIDTH-1:0]     x_q,       x_d;
    logic [V_WIDTH-1:0]     y_q,       y_d;
    logic [BC_W-1:0]        bar_cnt_q, bar_cnt_d;
    logic [2:0]             bar_idx_q, bar_idx_d;
    logic [1:0]             pat_q,     pat_d;
    logic [PIXEL_WIDTH-1:0] fill_q,    fill_d;
    logic                   valid_q,   valid_d;
    logic                   busy_q,    busy_d;
    logic                   done_q,    done_d;
    logic [PIXEL_WIDTH-1:0] pixel_q,   pixel_d;

    // Frame walker: start latch, raster advance on handshake, bar counter without a divider.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        bar_cnt_d = bar_cnt_q;
        bar_idx_d = bar_idx_q;
        pat_d     = pat_q;
        fill_d    = fill_q;
        valid_d   = valid_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_RUN;
                    pat_d     = pattern;
                    fill_d    = fill_color;
                    x_d       = '0;
                    y_d       = '0;
                    bar_cnt_d = '0;
                    bar_idx_d = '0;
                    valid_d   = 1'b1;
                    busy_d    = 1'b1;
                end
            end
            S_RUN: begin
                if (valid_q && m_gfx_ready) begin
                    if (x_q == X_LAST) begin
                        // End of line: bars restart at the left edge.
                        x_d       = '0;
                        bar_cnt_d = '0;
                        bar_idx_d = '0;
                        if (y_q == Y_LAST) begin
                            state_d = S_DONE;
                            valid_d = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            y_d = y_q + 1'b1;
                        end
                    end else begin
                        x_d = x_q + 1'b1;
                        if (bar_cnt_q == BC_LAST) begin
                            bar_cnt_d = '0;
                            bar_idx_d = bar_idx_q + 1'b1;
                        end else begin
                            bar_cnt_d = bar_cnt_q + 1'b1;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Color of the next beat, computed from next-state coordinates so the pixel register lines up with x/y.
    always_comb begin
        pixel_d = '0;
        case (pat_d)
            2'd0: pixel_d = fill_d;
            2'd1: pixel_d = {{COLOR_WIDTH{bar_idx_d[2]}},
                             {COLOR_WIDTH{bar_idx_d[1]}},
                             {COLOR_WIDTH{bar_idx_d[0]}}};
            2'd2: pixel_d = (x_d[4] ^ y_d[4]) ? {PIXEL_WIDTH{1'b1}} : {PIXEL_WIDTH{1'b0}};
            2'd3: pixel_d = {x_d[COLOR_WIDTH+4:5], y_d[COLOR_WIDTH+4:5], {COLOR_WIDTH{1'b0}}};
            default: pixel_d = '0;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            bar_cnt_q <= '0;
            bar_idx_q <= '0;
            pat_q     <= '0;
            fill_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pixel_q   <= '0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            bar_cnt_q <= bar_cnt_d;
            bar_idx_q <= bar_idx_d;
            pat_q     <= pat_d;
            fill_q    <= fill_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pixel_q   <= pixel_d;
        end
    end

    assign m_gfx_valid = valid_q;
    assign m_gfx_x     = x_q;
    assign m_gfx_y     = y_q;
    assign m_gfx_pixel = pixel_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_gfx_pattern_gen.sv
// Bench for gfx_pattern_gen on a reduced 64x66 raster.
// Scoreboard of every beat plus per-pattern spot vectors and hand-written corner sequences.
// Ready is either held high or randomized to exercise stalls.
module tb_gfx_pattern_gen;

    localparam int H  = 64;
    localparam int V  = 66;
    localparam int NV = 16;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  pattern;
    logic [11:0] fill_color;
    logic        busy;
    logic        done;
    logic        m_gfx_valid;
    logic        m_gfx_ready;
    logic [11:0] m_gfx_x;
    logic [11:0] m_gfx_y;
    logic [11:0] m_gfx_pixel;

    gfx_pattern_gen #(
        .H_VISIBLE(H), .V_VISIBLE(V), .H_WIDTH(12), .V_WIDTH(12), .COLOR_WIDTH(4)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .pattern(pattern), .fill_color(fill_color),
        .busy(busy), .done(done), .m_gfx_valid(m_gfx_valid), .m_gfx_ready(m_gfx_ready),
        .m_gfx_x(m_gfx_x), .m_gfx_y(m_gfx_y), .m_gfx_pixel(m_gfx_pixel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] x;
        logic [11:0] y;
        logic [11:0] pix;
    } beat_t;

    typedef struct {
        logic [1:0]  pat;
        logic [11:0] fill;
        int          x;
        int          y;
        logic [11:0] exp;
    } vec_t;

    beat_t       exp_q[$];
    beat_t       mon_e;
    vec_t        vecs[NV];
    logic [11:0] seen[H*V];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_hs  = 0;
    int beats    = 0;
    int done_cnt = 0;
    int valid_cycles = 0;
    bit mon_en     = 1'b0;
    bit done_seen  = 1'b0;
    bit prev_stall = 1'b0;
    logic [11:0] stall_x, stall_y, stall_pix;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference color model, written from the pattern definitions.
    function automatic logic [11:0] model(input logic [1:0] pat, input logic [11:0] fc,
                                          input int x, input int y);
        logic [2:0] bi;
        logic [3:0] r, g;
        case (pat)
            2'd0: return fc;
            2'd1: begin
                bi = 3'(x / (H / 8));
                return {{4{bi[2]}}, {4{bi[1]}}, {4{bi[0]}}};
            end
            2'd2: return ((((x >> 4) ^ (y >> 4)) & 1) != 0) ? 12'hFFF : 12'h000;
            default: begin
                r = 4'((x >> 5) & 15);
                g = 4'((y >> 5) & 15);
                return {r, g, 4'h0};
            end
        endcase
    endfunction

    // Monitor on the falling edge: scoreboard pops, stall stability, done timing.
    always @(negedge clk) begin
        cyc++;
        if (mon_en) begin
            if (prev_stall)
                check("stall_hold", {m_gfx_valid, m_gfx_x, m_gfx_y, m_gfx_pixel},
                      {1'b1, stall_x, stall_y, stall_pix});
            prev_stall = m_gfx_valid && !m_gfx_ready;
            stall_x    = m_gfx_x;
            stall_y    = m_gfx_y;
            stall_pix  = m_gfx_pixel;
            if (m_gfx_valid) valid_cycles++;
            if (m_gfx_valid && m_gfx_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", 64'd1, 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("beat", {m_gfx_x, m_gfx_y, m_gfx_pixel}, {mon_e.x, mon_e.y, mon_e.pix});
                end
                if (int'(m_gfx_x) < H && int'(m_gfx_y) < V)
                    seen[int'(m_gfx_y) * H + int'(m_gfx_x)] = m_gfx_pixel;
                beats++;
                last_hs = cyc;
            end
            if (done) begin
                done_cnt++;
                done_seen = 1'b1;
                check("done_timing", 64'(cyc - last_hs), 64'd1);
                check("done_busy", {63'd0, busy}, 64'd1);
            end
        end
    end

    // Paints one frame; must be entered just after a rising edge. mode 0: ready high, 1: random ready.
    task automatic run_frame(input logic [1:0] pat, input logic [11:0] fc, input int mode, input bit poke);
        int n;
        exp_q.delete();
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++)
                exp_q.push_back('{12'(x), 12'(y), model(pat, fc, x, y)});
        for (int i = 0; i < H*V; i++) seen[i] = 12'hxxx;
        beats = 0; done_cnt = 0; valid_cycles = 0; done_seen = 1'b0; prev_stall = 1'b0;
        mon_en = 1'b1;
        start = 1'b1; pattern = pat; fill_color = fc;
        m_gfx_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        start = 1'b0; pattern = ~pat; fill_color = ~fc;
        check("start_first_beat", {m_gfx_valid, busy, m_gfx_x, m_gfx_y}, {1'b1, 1'b1, 24'h0});
        n = 0;
        while (!done_seen && n < H*V*8) begin
            if (mode == 1) m_gfx_ready = 1'($urandom_range(0, 1));
            if (poke && n == 20) begin
                start = 1'b1; pattern = 2'd2; fill_color = 12'h000;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        check("frame_finished", {63'd0, done_seen}, 64'd1);
        check("beat_count", 64'(beats), 64'(H*V));
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        if (mode == 0) check("no_gaps", 64'(valid_cycles), 64'(H*V));
        check("idle_after_done", {61'd0, busy, done, m_gfx_valid}, 64'd0);
        check("done_once", 64'(done_cnt), 64'd1);
        for (int i = 0; i < NV; i++)
            if (vecs[i].pat == pat && (pat != 2'd0 || vecs[i].fill == fc))
                check($sformatf("vec_p%0d_x%0d_y%0d", pat, vecs[i].x, vecs[i].y),
                      {52'd0, seen[vecs[i].y * H + vecs[i].x]}, {52'd0, vecs[i].exp});
    endtask

    initial begin
        int k, n;
        vecs[0]  = '{2'd2, 12'h000,  0,  0, 12'h000};
        vecs[1]  = '{2'd2, 12'h000, 16,  0, 12'hFFF};
        vecs[2]  = '{2'd2, 12'h000, 16, 16, 12'h000};
        vecs[3]  = '{2'd2, 12'h000, 63, 65, 12'hFFF};
        vecs[4]  = '{2'd1, 12'h000,  0,  5, 12'h000};
        vecs[5]  = '{2'd1, 12'h000,  8,  5, 12'h00F};
        vecs[6]  = '{2'd1, 12'h000, 32,  5, 12'hF00};
        vecs[7]  = '{2'd1, 12'h000, 63,  5, 12'hFFF};
        vecs[8]  = '{2'd1, 12'h000,  0,  6, 12'h000};
        vecs[9]  = '{2'd1, 12'h000, 15,  0, 12'h00F};
        vecs[10] = '{2'd1, 12'h000, 16,  0, 12'h0F0};
        vecs[11] = '{2'd3, 12'h000, 33, 65, 12'h120};
        vecs[12] = '{2'd3, 12'h000,  0,  0, 12'h000};
        vecs[13] = '{2'd3, 12'h000, 63, 63, 12'h110};
        vecs[14] = '{2'd0, 12'hA5C,  0,  0, 12'hA5C};
        vecs[15] = '{2'd0, 12'hA5C, 63, 65, 12'hA5C};

        rst = 1'b1; start = 1'b0; pattern = 2'd0; fill_color = 12'h000; m_gfx_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", {m_gfx_valid, busy, done, m_gfx_x, m_gfx_y, m_gfx_pixel}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_after_reset", {61'd0, m_gfx_valid, busy, done}, 64'd0);

        // Checkerboard, then color bars started the very cycle busy falls.
        run_frame(2'd2, 12'h000, 0, 1'b0);
        run_frame(2'd1, 12'h000, 0, 1'b0);
        // Gradient under random backpressure.
        run_frame(2'd3, 12'h000, 1, 1'b0);
        // Solid fill with a stray start mid-frame.
        run_frame(2'd0, 12'hA5C, 0, 1'b1);

        // Reset in the middle of a frame.
        mon_en = 1'b0;
        exp_q.delete();
        start = 1'b1; pattern = 2'd1; m_gfx_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0; n = 0;
        while (k < 1000 && n < 5000) begin
            @(negedge clk);
            if (m_gfx_valid && m_gfx_ready) k++;
            n++;
        end
        check("reached_beat_1000", 64'(k), 64'd1000);
        rst = 1'b1;
        @(posedge clk); #1;
        check("reset_midframe", {m_gfx_valid, busy, done, m_gfx_x, m_gfx_y, m_gfx_pixel}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("no_beats_after_reset", {62'd0, m_gfx_valid, busy}, 64'd0);
        end
        @(posedge clk); #1;
        run_frame(2'd3, 12'h000, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
